// File: rtl/convert10to4.sv
// convert10to4: transmit-side 10-bit to 4-bit gearbox.
// 10-bit words enter through a valid/ready handshake. They leave as a continuous
// LSB-first stream of 4-bit chunks, one chunk per clock. A 16-bit bit buffer holds
// the bits that have not been sent; bit 0 of the buffer is the oldest bit.
//
// Handshake: a word transfers on a rising edge where din_valid and din_ready are
// both high. din_ready is combinational. It depends only on flush and on the fill
// level left after this edge's emit, and never on din_valid. The source may hold
// din_valid high for as long as it likes; only cycles with din_ready high consume
// a word.
module convert10to4 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic [9:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [3:0] dout,
  output logic       dout_valid,
  output logic       underrun
);

  // Buffered stream bits. Bits at positions >= fill_q are stale and never emitted.
  logic [15:0] bits_q;
  logic [4:0]  fill_q;
  // Set once the first chunk has gone out, so that an empty buffer counts as starvation.
  logic        primed_q;

  logic        emit;
  logic        accept;
  logic [4:0]  fill_post;
  logic [4:0]  fill_next;
  logic [15:0] bits_post;
  logic [15:0] ins_mask;
  logic [15:0] ins_data;
  logic [15:0] bits_next;

  // Work out this edge's emit and accept decisions and the next buffer contents.
  always_comb begin
    emit      = (fill_q >= 5'd4);
    fill_post = emit ? (fill_q - 5'd4) : fill_q;
    bits_post = emit ? {4'b0000, bits_q[15:4]} : bits_q;
    // Accepting only when at most 6 bits remain after the shift keeps the
    // buffer at 16 bits or fewer.
    din_ready = !flush && (fill_post <= 5'd6);
    accept    = din_valid && din_ready;
    // Place the new word directly above the bits that remain after the shift.
    ins_mask  = 16'h03ff << fill_post;
    ins_data  = {6'b000000, din} << fill_post;
    bits_next = accept ? ((bits_post & ~ins_mask) | ins_data) : bits_post;
    fill_next = accept ? (fill_post + 5'd10) : fill_post;
  end

  // Update the buffer and the registered outputs; flush and reset clear everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bits_q     <= '0;
      fill_q     <= '0;
      primed_q   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      underrun   <= 1'b0;
    end else if (flush) begin
      bits_q     <= '0;
      fill_q     <= '0;
      primed_q   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      bits_q <= bits_next;
      fill_q <= fill_next;
      if (emit) begin
        dout       <= bits_q[3:0];
        dout_valid <= 1'b1;
        primed_q   <= 1'b1;
      end else begin
        // dout is forced to zero so that stale buffer bits never leak out.
        dout       <= '0;
        dout_valid <= 1'b0;
        if (primed_q) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/convert10to4.md
# convert10to4

Transmit-side gearbox for the camera LVDS data path. It accepts 10-bit pixel words over a valid/ready handshake and emits them as a continuous LSB-first stream of 4-bit chunks, one chunk per clock, for the 4-bit-wide serializer front end. Its output ordering is the exact inverse of the receive-side 4→10 gearbox: chunk k carries stream bits 4k..4k+3, and word n occupies stream bits 10n..10n+9. It sits between the pixel/test-pattern source and the output SERDES in the sensor-emulation transmit path.

## Interface
- Parameters: none. The block is fixed at 10-bit words and 4-bit chunks.
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous clear of buffer and status; has priority over all other activity.
- din  in  10  pixel word; bit 0 is transmitted first.
- din_valid  in  1  din holds a word.
- din_ready  out  1  combinational; the block accepts din on this edge.
- dout  out  4  chunk to the serializer; dout[0] is the earliest stream bit.
- dout_valid  out  1  dout holds real data.
- underrun  out  1  sticky; the stream starved after it had started.

## Operation
- State: 16-bit bit buffer B, where B[0] is the oldest bit; fill count F in 0..16; flag primed; registers dout, dout_valid, underrun.
- emit = (F ≥ 4).
- din_ready = !flush && ((F − (emit ? 4 : 0)) ≤ 6).
- accept = din_valid && din_ready.
- Each edge, when flush = 0:
  - If emit: dout ← B[3:0], dout_valid ← 1, B shifts right by 4, primed ← 1.
  - If !emit: dout ← 0, dout_valid ← 0.
  - If accept: din is written at bit positions [F' .. F'+9] of the post-shift buffer, where F' = F − (emit ? 4 : 0).
  - F ← F' + (accept ? 10 : 0).
- Emit and accept in the same cycle are legal. Because of the ready rule, F never exceeds 16 and no bits are lost.
- Underrun: if primed && !emit, then underrun ← 1. It stays set until flush or reset.
- Flush: F ← 0, B ← 0, primed ← 0, dout ← 0, dout_valid ← 0, underrun ← 0. din_ready is low, so no word is accepted in that cycle.
- Reset (reset_n low, asynchronous): same state as flush. Reset asserted mid-stream discards all buffered bits. The partial word is not completed.
- Words are never split across a flush. A word accepted on the flush edge cannot occur because din_ready is low.
- Bits beyond F are don't-care internally, but they must never reach dout. dout is 0 whenever dout_valid = 0.

## Timing
- Output reset values: dout = 0, dout_valid = 0, underrun = 0, din_ready = 1 (because F = 0).
- Latency: a word accepted at edge k with F = 0 appears as dout = din[3:0], with dout_valid = 1, after edge k+1.
- Sustained throughput: 2 words per 5 clocks.
- Continuous-source sequence from empty, with din_valid held high. F after each edge: 10, 16, 12, 8, 14, 10, 16, ...
  - din_ready pattern from the first edge: 1,1,0,0,1,0,1,... This repeats with period 5 after edge 1.
- dout_valid stays high continuously once the source sustains at least 40% valid.
- Worst-case acceptance gap: 2 consecutive cycles with din_ready low.

## Test plan
- Reset/idle:
  - Stimulus: hold reset_n low, then release; din_valid = 0 for 10 cycles.
  - Required: dout = 0, dout_valid = 0, underrun = 0 and din_ready = 1 throughout.
- Ordering:
  - Stimulus: words 0x2D5 then 0x0F3, presented back-to-back from empty.
  - Required: dout = 0x5, 0xD, 0xE, 0xC, 0x3 on 5 consecutive valid cycles, then dout_valid = 0.
  - Required: underrun = 1 from the cycle after the last chunk.
- Backpressure:
  - Stimulus: din_valid held high with an incrementing word source for 1000 cycles.
  - Required: din_ready follows the pattern 1,1,0,0,1,0,1,...; dout_valid never drops after the first chunk; underrun stays 0.
  - Required: the reassembled stream, fed through a model of the receive 4→10 gearbox, matches the source exactly.
- Starvation:
  - Stimulus: a single word 0x3FF.
  - Required: chunks 0xF, 0xF, then a stall; dout_valid = 0 with dout = 0, and underrun sets.
  - Stimulus: feed 0x000 next.
  - Required: next chunk is 0x3 (0x3FF[9:8] with 0x000[1:0]); underrun stays 1.
- Flush:
  - Stimulus: pulse flush for 1 cycle while F = 12 with din_valid high.
  - Required: no word is accepted on that edge; after the edge, dout_valid = 0, underrun = 0 and F = 0.
  - Required: the next accepted word emits its bits [3:0] first.
- Async reset mid-stream:
  - Stimulus: drop reset_n between clock edges during a streaming run.
  - Required: all outputs go to their reset values immediately, without waiting for a clock edge.
  - Required: after release, streaming restarts cleanly from the next accepted word.
